spi_cmd_ctrl: RTL and testbench

SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

---
 rtl/spi_cmd_ctrl.sv | 138 +++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: turns two-word SPI transactions (command, then data or dummy)
// into single-cycle register-bank read/write strobes. Read data is returned
// on the tx stream between the command word and the dummy word.
module spi_cmd_ctrl #(
  parameter int DATA_LEN       = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_LEN-1:0] rx_tdata,
  input  logic                rx_tvalid,
  output logic                rx_tready,
  output logic [DATA_LEN-1:0] tx_tdata,
  output logic                tx_tvalid,
  input  logic                tx_tready,
  output logic [DATA_LEN-2:0] reg_addr,
  output logic [DATA_LEN-1:0] reg_wdata,
  output logic                reg_we,
  output logic                reg_re,
  input  logic [DATA_LEN-1:0] reg_rdata,
  output logic                busy,
  output logic [7:0]          timeout_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_CAP,
    ST_TX_OFFER,
    ST_WAIT_DATA,
    ST_WR_EXEC
  } state_t;

  state_t        state_reg;
  logic          rw_reg;
  logic [TW-1:0] tmo_reg;
  logic          rx_fire;
  logic          tmo_hit;

  assign rx_fire = rx_tvalid & rx_tready;
  // Timer counts cycles already spent in the waiting state; the last one expires.
  assign tmo_hit = (tmo_reg == TW'(TIMEOUT_CYCLES - 1));
  assign busy    = (state_reg != ST_IDLE);

  // Transaction FSM; every interface output is a register set on the transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      rw_reg      <= 1'b0;
      tmo_reg     <= '0;
      rx_tready   <= 1'b0;
      tx_tdata    <= '0;
      tx_tvalid   <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          rx_tready <= 1'b1;
          if (rx_fire) begin
            reg_addr <= rx_tdata[DATA_LEN-2:0];
            rw_reg   <= rx_tdata[DATA_LEN-1];
            if (rx_tdata[DATA_LEN-1]) begin
              rx_tready <= 1'b0;
              reg_re    <= 1'b1;
              state_reg <= ST_RD_REQ;
            end else begin
              tmo_reg   <= '0;
              state_reg <= ST_WAIT_DATA;
            end
          end
        end
        ST_RD_REQ: begin
          reg_re    <= 1'b0;
          state_reg <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          // reg_rdata is valid in this cycle, one after the reg_re pulse.
          tx_tdata  <= reg_rdata;
          tx_tvalid <= 1'b1;
          tmo_reg   <= '0;
          state_reg <= ST_TX_OFFER;
        end
        ST_TX_OFFER: begin
          // A handshake on the expiry cycle takes priority over the timeout.
          if (tx_tready) begin
            tx_tvalid <= 1'b0;
            rx_tready <= 1'b1;
            tmo_reg   <= '0;
            state_reg <= ST_WAIT_DATA;
          end else if (tmo_hit) begin
            tx_tvalid <= 1'b0;
            rx_tready <= 1'b1;
            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            state_reg <= ST_IDLE;
          end else begin
            tmo_reg <= tmo_reg + TW'(1);
          end
        end
        ST_WAIT_DATA: begin
          if (rx_fire) begin
            if (rw_reg) begin
              state_reg <= ST_IDLE;
            end else begin
              reg_wdata <= rx_tdata;
              rx_tready <= 1'b0;
              state_reg <= ST_WR_EXEC;
            end
          end else if (tmo_hit) begin
            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            state_reg <= ST_IDLE;
          end else begin
            tmo_reg <= tmo_reg + TW'(1);
          end
        end
        ST_WR_EXEC: begin
          // First cycle lets reg_wdata settle; the strobe follows in the second.
          if (!reg_we) begin
            reg_we <= 1'b1;
          end else begin
            reg_we    <= 1'b0;
            rx_tready <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Testbench for spi_cmd_ctrl. Instance 0 uses a 16-cycle timeout, instance 1
// the default so long backpressure never expires. A scoreboard holds the
// expected register strobes and tx words; step() checks them every cycle.
module tb_spi_cmd_ctrl;
  localparam int DL = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DL-1:0] rx_tdata    [2];
  logic          rx_tvalid   [2];
  logic          rx_tready   [2];
  logic [DL-1:0] tx_tdata    [2];
  logic          tx_tvalid   [2];
  logic          tx_tready   [2];
  logic [DL-2:0] reg_addr    [2];
  logic [DL-1:0] reg_wdata   [2];
  logic          reg_we      [2];
  logic          reg_re      [2];
  logic [DL-1:0] reg_rdata   [2];
  logic          busy        [2];
  logic [7:0]    timeout_cnt [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    spi_cmd_ctrl #(
      .DATA_LEN      (DL),
      .TIMEOUT_CYCLES(gi == 0 ? 16 : 4096)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_tdata   (rx_tdata[gi]),
      .rx_tvalid  (rx_tvalid[gi]),
      .rx_tready  (rx_tready[gi]),
      .tx_tdata   (tx_tdata[gi]),
      .tx_tvalid  (tx_tvalid[gi]),
      .tx_tready  (tx_tready[gi]),
      .reg_addr   (reg_addr[gi]),
      .reg_wdata  (reg_wdata[gi]),
      .reg_we     (reg_we[gi]),
      .reg_re     (reg_re[gi]),
      .reg_rdata  (reg_rdata[gi]),
      .busy       (busy[gi]),
      .timeout_cnt(timeout_cnt[gi])
    );
  end

  int total = 0;
  int bad   = 0;
  int we_seen = 0;
  int re_seen = 0;

  logic [14:0] exp_we [$];
  logic [6:0]  exp_re [$];
  logic [7:0]  exp_tx [$];
  logic [7:0]  mem [128];
  int          rd_stage [2];
  logic [6:0]  rd_addr  [2];

  // One clock: register-bank model plus scoreboard checks on both instances.
  task automatic step();
    logic       hs [2];
    logic [7:0] hd [2];
    logic [14:0] ew;
    logic [7:0]  et;
    logic [6:0]  ea;
    for (int d = 0; d < 2; d++) begin
      hs[d] = tx_tvalid[d] && tx_tready[d];
      hd[d] = tx_tdata[d];
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (hs[d]) begin
        total++;
        if (exp_tx.size() == 0) begin
          bad++;
          $display("FAIL tx_unexpected dut%0d: got %h, expected none", d, hd[d]);
        end else begin
          et = exp_tx.pop_front();
          if (hd[d] !== et) begin
            bad++;
            $display("FAIL tx_data dut%0d: got %h, expected %h", d, hd[d], et);
          end
        end
      end
      // Bank model: data valid exactly the cycle after reg_re, junk otherwise.
      if (rd_stage[d] == 2) begin
        reg_rdata[d] = 8'hEE;
        rd_stage[d]  = 0;
      end else if (rd_stage[d] == 1) begin
        reg_rdata[d] = mem[rd_addr[d]];
        rd_stage[d]  = 2;
      end
      if (reg_re[d] === 1'b1) begin
        re_seen++;
        rd_addr[d]  = reg_addr[d];
        rd_stage[d] = 1;
        total++;
        if (exp_re.size() == 0) begin
          bad++;
          $display("FAIL re_unexpected dut%0d: got addr %h, expected none", d, reg_addr[d]);
        end else begin
          ea = exp_re.pop_front();
          if (reg_addr[d] !== ea) begin
            bad++;
            $display("FAIL re_addr dut%0d: got %h, expected %h", d, reg_addr[d], ea);
          end
        end
      end
      if (reg_we[d] === 1'b1) begin
        we_seen++;
        mem[reg_addr[d]] = reg_wdata[d];
        total++;
        if (exp_we.size() == 0) begin
          bad++;
          $display("FAIL we_unexpected dut%0d: got %h/%h, expected none", d, reg_addr[d], reg_wdata[d]);
        end else begin
          ew = exp_we.pop_front();
          if ({reg_addr[d], reg_wdata[d]} !== ew) begin
            bad++;
            $display("FAIL we_addr_data dut%0d: got %h/%h, expected %h/%h",
                     d, reg_addr[d], reg_wdata[d], ew[14:8], ew[7:0]);
          end
        end
      end
      total++;
      if ((reg_we[d] & reg_re[d]) !== 1'b0) begin
        bad++;
        $display("FAIL we_re_overlap dut%0d: got we=%b re=%b, expected not both", d, reg_we[d], reg_re[d]);
      end
    end
  endtask

  // Offer one rx word and wait (bounded) for it to be accepted.
  task automatic send_word(input int d, input logic [7:0] w);
    bit ok = 0;
    rx_tdata[d]  = w;
    rx_tvalid[d] = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (rx_tready[d] === 1'b1) ok = 1;
      step();
    end
    rx_tvalid[d] = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rx_accept dut%0d: word %h got not accepted, expected accepted", d, w);
    end
  endtask

  task automatic do_write(input int d, input logic [6:0] a, input logic [7:0] v);
    exp_we.push_back({a, v});
    send_word(d, {1'b0, a});
    send_word(d, v);
    $display("txn dut%0d write addr=%h data=%h", d, a, v);
  endtask

  // Full read with tx_tready already high: command, wait for reply, dummy.
  task automatic do_read(input int d, input logic [6:0] a);
    exp_re.push_back(a);
    send_word(d, {1'b1, a});
    exp_tx.push_back(mem[a]);
    for (int n = 0; n < 20 && exp_tx.size() != 0; n++) step();
    total++;
    if (exp_tx.size() != 0) begin
      bad++;
      $display("FAIL read_reply dut%0d: got no tx word, expected %h", d, exp_tx[0]);
    end
    send_word(d, 8'h00);
    $display("txn dut%0d read addr=%h data=%h", d, a, mem[a]);
  endtask

  task automatic check_idle_outputs(input string name);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({rx_tready[d], tx_tvalid[d], tx_tdata[d], reg_addr[d], reg_wdata[d],
           reg_we[d], reg_re[d], busy[d], timeout_cnt[d]} !== '0) begin
        bad++;
        $display("FAIL %s dut%0d: got rdy=%b tv=%b td=%h a=%h wd=%h we=%b re=%b busy=%b tc=%0d, expected all 0",
                 name, d, rx_tready[d], tx_tvalid[d], tx_tdata[d], reg_addr[d], reg_wdata[d],
                 reg_we[d], reg_re[d], busy[d], timeout_cnt[d]);
      end
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_values");
    rst_n = 1'b1;
    check_bit("rdy_low_before_edge", rx_tready[0], 1'b0);
    step();
    check_bit("rdy_after_reset", rx_tready[0], 1'b1);
    $display("txn reset released");
  endtask

  task automatic test_write();
    int we0 = we_seen;
    exp_we.push_back({7'h05, 8'hA5});
    send_word(0, 8'h05);
    check_bit("wr_busy_wait_data", busy[0], 1'b1);
    send_word(0, 8'hA5);
    check_bit("wr_we_lat1", reg_we[0], 1'b0);
    step();
    check_bit("wr_we_lat2", reg_we[0], 1'b1);
    repeat (3) step();
    total++;
    if (we_seen - we0 != 1) begin
      bad++;
      $display("FAIL wr_we_count: got %0d, expected 1", we_seen - we0);
    end
    check_bit("wr_busy_end", busy[0], 1'b0);
    $display("txn dut0 write addr=05 data=a5");
  endtask

  task automatic test_read();
    int we0 = we_seen;
    logic [7:0] held;
    mem[3] = 8'h3C;
    tx_tready[0] = 1'b0;
    exp_re.push_back(7'h03);
    send_word(0, 8'h83);
    check_bit("rd_re_pulse", reg_re[0], 1'b1);
    exp_tx.push_back(8'h3C);
    step();
    check_bit("rd_tv_lat2", tx_tvalid[0], 1'b0);
    step();
    check_bit("rd_tv_lat3", tx_tvalid[0], 1'b1);
    held = tx_tdata[0];
    repeat (4) step();
    check_bit("rd_tv_hold", tx_tvalid[0], 1'b1);
    total++;
    if (tx_tdata[0] !== held) begin
      bad++;
      $display("FAIL rd_td_hold: got %h, expected %h", tx_tdata[0], held);
    end
    tx_tready[0] = 1'b1;
    step();
    check_bit("rd_tv_drop", tx_tvalid[0], 1'b0);
    send_word(0, 8'h00);
    repeat (3) step();
    total++;
    if (we_seen != we0 || exp_tx.size() != 0) begin
      bad++;
      $display("FAIL rd_no_we: got we=%0d txq=%0d, expected 0/0", we_seen - we0, exp_tx.size());
    end
    check_bit("rd_busy_end", busy[0], 1'b0);
    $display("txn dut0 read addr=03 data=3c");
  endtask

  task automatic test_back_to_back();
    do_write(0, 7'h20, 8'h11);
    do_read(0, 7'h20);
    do_write(0, 7'h7F, 8'hC3);
    do_read(0, 7'h7F);
    do_read(0, 7'h00);
    repeat (3) step();
    total++;
    if (exp_we.size() + exp_re.size() + exp_tx.size() != 0) begin
      bad++;
      $display("FAIL b2b_drain: got %0d pending, expected 0", exp_we.size() + exp_re.size() + exp_tx.size());
    end
  endtask

  task automatic test_timeout();
    logic [7:0] tc0 = timeout_cnt[0];
    send_word(0, 8'h01);
    repeat (15) step();
    check_bit("tmo_busy_before", busy[0], 1'b1);
    step();
    check_bit("tmo_busy_after", busy[0], 1'b0);
    total++;
    if (timeout_cnt[0] !== tc0 + 8'd1) begin
      bad++;
      $display("FAIL tmo_count: got %0d, expected %0d", timeout_cnt[0], tc0 + 8'd1);
    end
    $display("txn dut0 write addr=01 timed out");
    do_write(0, 7'h12, 8'h34);
    repeat (3) step();
    check_bit("tmo_next_done", exp_we.size() == 0, 1'b1);
  endtask

  task automatic test_timeout_handshake();
    logic [7:0] tc0 = timeout_cnt[0];
    mem[5] = 8'h5D;
    tx_tready[0] = 1'b0;
    exp_re.push_back(7'h05);
    send_word(0, 8'h85);
    exp_tx.push_back(8'h5D);
    repeat (17) step();
    check_bit("tmohs_tv_still", tx_tvalid[0], 1'b1);
    tx_tready[0] = 1'b1;
    step();
    tx_tready[0] = 1'b0;
    check_bit("tmohs_wait_data", busy[0], 1'b1);
    total++;
    if (timeout_cnt[0] !== tc0 || exp_tx.size() != 0) begin
      bad++;
      $display("FAIL tmohs_count: got tc=%0d txq=%0d, expected tc=%0d txq=0", timeout_cnt[0], exp_tx.size(), tc0);
    end
    tx_tready[0] = 1'b1;
    send_word(0, 8'h00);
    step();
    check_bit("tmohs_idle", busy[0], 1'b0);
    $display("txn dut0 read addr=05 handshake on expiry cycle");
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    int errs = 0;
    mem[7] = 8'h96;
    tx_tready[1] = 1'b0;
    exp_re.push_back(7'h07);
    send_word(1, 8'h87);
    exp_tx.push_back(8'h96);
    step();
    step();
    check_bit("bp_tv_up", tx_tvalid[1], 1'b1);
    held = tx_tdata[1];
    for (int n = 0; n < 50; n++) begin
      step();
      total++;
      if (tx_tvalid[1] !== 1'b1 || tx_tdata[1] !== held) begin
        bad++;
        errs++;
        if (errs < 4) $display("FAIL bp_hold cycle %0d: got tv=%b td=%h, expected 1/%h", n, tx_tvalid[1], tx_tdata[1], held);
      end
    end
    tx_tready[1] = 1'b1;
    step();
    check_bit("bp_tv_drop", tx_tvalid[1], 1'b0);
    send_word(1, 8'h00);
    step();
    check_bit("bp_idle", busy[1], 1'b0);
    total++;
    if (timeout_cnt[1] !== 8'd0 || exp_tx.size() != 0) begin
      bad++;
      $display("FAIL bp_done: got tc=%0d txq=%0d, expected 0/0", timeout_cnt[1], exp_tx.size());
    end
    $display("txn dut1 read addr=07 after 50 cycles backpressure");
  endtask

  task automatic test_reset_mid();
    int we0 = we_seen;
    send_word(0, 8'h09);
    send_word(0, 8'h77);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset_values");
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check_bit("mid_rdy_after", rx_tready[0], 1'b1);
    total++;
    if (we_seen != we0) begin
      bad++;
      $display("FAIL mid_no_we: got %0d pulses, expected 0", we_seen - we0);
    end
    $display("txn dut0 write addr=09 aborted by reset");
    do_write(0, 7'h0A, 8'h5A);
    repeat (3) step();
    total++;
    if (we_seen != we0 + 1 || mem[10] !== 8'h5A) begin
      bad++;
      $display("FAIL mid_next: got pulses=%0d mem=%h, expected 1/5a", we_seen - we0, mem[10]);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i * 29 + 7);
    for (int d = 0; d < 2; d++) begin
      rx_tdata[d]  = '0;
      rx_tvalid[d] = 1'b0;
      tx_tready[d] = 1'b1;
      reg_rdata[d] = 8'hEE;
      rd_stage[d]  = 0;
      rd_addr[d]   = '0;
    end
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_timeout();
    test_timeout_handshake();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
